// File: rtl/reg_array_ctrl.sv
// reg_array_ctrl: access sequencer for an array of DEPTH words of WIDTH 1-bit cells.
// Accepts read/write requests on a valid/ready channel, drives the shared cell strobes
// (active-low), the one-hot word enable and the write-data bus, and returns sampled read
// data on a valid/ready response channel.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only while idle)
//   req_wr, req_addr, req_wdata     request type, word address, write data
//   rsp_valid/rsp_ready             read response handshake
//   rsp_rdata, rsp_err              read data, out-of-range flag
//   wr_done                         one-cycle pulse when a write completes
//   cell_en                         one-hot word enable to the cells
//   cell_rd_bar, cell_wr_bar        active-low read/write strobes
//   cell_din                        write data bus to the cells
//   cell_dout                       resolved tristate read bus from the cells
module reg_array_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             wr_done,
    output logic [DEPTH-1:0] cell_en,
    output logic             cell_rd_bar,
    output logic             cell_wr_bar,
    output logic [WIDTH-1:0] cell_din,
    input  logic [WIDTH-1:0] cell_dout
);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_t;

    state_t           state_q, state_d;
    logic             oor_q, oor_d;
    logic [DEPTH-1:0] cell_en_d;
    logic             cell_rd_bar_d, cell_wr_bar_d;
    logic [WIDTH-1:0] cell_din_d;
    logic             rsp_valid_d, rsp_err_d, wr_done_d;
    logic [WIDTH-1:0] rsp_rdata_d;
    logic             in_range;
    logic [DEPTH-1:0] addr_onehot;

    assign req_ready = (state_q == StIdle);
    assign in_range  = (32'(req_addr) < DEPTH);

    // Out-of-range addresses decode to no word at all.
    always_comb begin
        addr_onehot = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_onehot[i] = (32'(req_addr) == i);
        end
    end

    always_comb begin
        state_d       = state_q;
        oor_d         = oor_q;
        cell_en_d     = cell_en;
        cell_rd_bar_d = cell_rd_bar;
        cell_wr_bar_d = cell_wr_bar;
        cell_din_d    = cell_din;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        wr_done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cell_en_d = addr_onehot;
                    oor_d     = !in_range;
                    if (req_wr) begin
                        state_d       = StWr;
                        cell_din_d    = req_wdata;
                        cell_wr_bar_d = 1'b0;
                    end else begin
                        state_d       = StRd;
                        cell_rd_bar_d = 1'b0;
                    end
                end
            end
            StWr: begin
                cell_wr_bar_d = 1'b1;
                cell_en_d     = '0;
                wr_done_d     = 1'b1;
                state_d       = StIdle;
            end
            StRd: begin
                // The bus is undriven for an out-of-range read, so never sample it.
                rsp_rdata_d   = oor_q ? '0 : cell_dout;
                rsp_err_d     = oor_q;
                rsp_valid_d   = 1'b1;
                cell_rd_bar_d = 1'b1;
                cell_en_d     = '0;
                state_d       = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            oor_q       <= 1'b0;
            cell_en     <= '0;
            cell_rd_bar <= 1'b1;
            cell_wr_bar <= 1'b1;
            cell_din    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            wr_done     <= 1'b0;
        end else begin
            state_q     <= state_d;
            oor_q       <= oor_d;
            cell_en     <= cell_en_d;
            cell_rd_bar <= cell_rd_bar_d;
            cell_wr_bar <= cell_wr_bar_d;
            cell_din    <= cell_din_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            wr_done     <= wr_done_d;
        end
    end

    a_en_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(cell_en));
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(!cell_rd_bar && !cell_wr_bar));
    a_en_in_access: assert property (@(posedge clk) disable iff (!rst_n)
        (cell_en != '0) |-> (state_q == StWr || state_q == StRd));
    a_no_accept_in_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_valid && req_ready && rsp_valid));

endmodule
